// File: rtl/wishbone_arbiter_rr.sv
// Two-master round-robin Wishbone arbiter in front of a single slave port.
// A master owns the bus for as long as it holds CYC. A watchdog returns ERR
// to the granted master if the slave leaves a strobe unanswered for too long.
module wishbone_arbiter_rr #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  // master 0 (CPU core)
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  input  logic              m0_we_i,
  input  logic              m0_stb_i,
  input  logic              m0_cyc_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  // master 1 (network interface)
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  input  logic              m1_we_i,
  input  logic              m1_stb_i,
  input  logic              m1_cyc_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  // shared slave port
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  output logic              s_we_o,
  output logic              s_stb_o,
  output logic              s_cyc_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_reg, state_next;
  // Index of the master granted most recently; the other one wins a tie.
  logic last_grant_reg, last_grant_next;

  // Master inputs gathered into indexable form so the mux is written once.
  logic [ADDR_W-1:0] m_addr [2];
  logic [DATA_W-1:0] m_data [2];
  logic [1:0]        m_we;
  logic [1:0]        m_stb;
  logic [1:0]        m_cyc;

  assign m_addr[0] = m0_addr_i;
  assign m_addr[1] = m1_addr_i;
  assign m_data[0] = m0_data_i;
  assign m_data[1] = m1_data_i;
  assign m_we      = {m1_we_i,  m0_we_i};
  assign m_stb     = {m1_stb_i, m0_stb_i};
  assign m_cyc     = {m1_cyc_i, m0_cyc_i};

  logic [1:0] grant;
  logic       granted;
  logic       sel;
  logic       state_change;
  logic       timed_out;
  logic       wd_fire;

  assign grant        = {state_reg == GNT1, state_reg == GNT0};
  assign granted      = |grant;
  assign sel          = grant[1];
  assign state_change = (state_next != state_reg);

  // State and round-robin pointer registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Next-state: arbitrate only from IDLE, so every release costs one idle cycle.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (m_cyc[0] && m_cyc[1]) begin
          state_next = last_grant_reg ? GNT0 : GNT1;
        end else if (m_cyc[0]) begin
          state_next = GNT0;
        end else if (m_cyc[1]) begin
          state_next = GNT1;
        end
      end
      GNT0: begin
        if (!m_cyc[0]) begin
          state_next      = IDLE;
          last_grant_next = 1'b0;
        end
      end
      GNT1: begin
        if (!m_cyc[1]) begin
          state_next      = IDLE;
          last_grant_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Slave port mux: granted master passes through, otherwise all zero.
  always_comb begin
    s_addr_o = '0;
    s_data_o = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    if (granted) begin
      s_addr_o = m_addr[sel];
      s_data_o = m_data[sel];
      s_we_o   = m_we[sel];
      s_cyc_o  = m_cyc[sel];
      // A timed-out strobe is withheld until the master drops it.
      s_stb_o  = m_stb[sel] & ~timed_out;
    end
  end

  // Per-master response routing; a master not granted never sees ack or err.
  logic [1:0] m_ack;
  logic [1:0] m_err;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      assign m_ack[gi] = grant[gi] & s_ack_i;
      assign m_err[gi] = grant[gi] & wd_fire;
    end
  endgenerate

  assign m0_ack_o  = m_ack[0];
  assign m1_ack_o  = m_ack[1];
  assign m0_err_o  = m_err[0];
  assign m1_err_o  = m_err[1];
  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int CNT_W = $clog2(TIMEOUT + 1);

      logic [CNT_W-1:0] count_reg, count_next;
      logic             timed_out_reg, timed_out_next;

      // Fires on the TIMEOUT-th consecutive unanswered strobe cycle; ACK wins.
      assign wd_fire = s_stb_o & ~s_ack_i & (count_reg == CNT_W'(TIMEOUT - 1));

      // Wait counter: runs only while a strobe is outstanding.
      always_comb begin
        count_next = '0;
        if (!state_change && s_stb_o && !s_ack_i && !wd_fire) begin
          count_next = count_reg + 1'b1;
        end
      end

      // Timed-out flag: set by the watchdog, cleared when the strobe or grant goes.
      always_comb begin
        timed_out_next = timed_out_reg;
        if (state_change) begin
          timed_out_next = 1'b0;
        end else if (wd_fire) begin
          timed_out_next = 1'b1;
        end else if (granted && !m_stb[sel]) begin
          timed_out_next = 1'b0;
        end
      end

      // Watchdog registers.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          count_reg     <= '0;
          timed_out_reg <= 1'b0;
        end else begin
          count_reg     <= count_next;
          timed_out_reg <= timed_out_next;
        end
      end

      assign timed_out = timed_out_reg;
    end else begin : g_no_wd
      assign wd_fire   = 1'b0;
      assign timed_out = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wishbone_arbiter_rr.sv
// Directed bench for the two-master round-robin Wishbone arbiter.
module tb_wishbone_arbiter_rr;

  logic        clk;
  logic        rst_n;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;

  int checks   = 0;
  int failures = 0;

  wishbone_arbiter_rr #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(16)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .m0_addr_i(m0_addr),
    .m0_data_i(m0_wdata),
    .m0_we_i  (m0_we),
    .m0_stb_i (m0_stb),
    .m0_cyc_i (m0_cyc),
    .m0_data_o(m0_rdata),
    .m0_ack_o (m0_ack),
    .m0_err_o (m0_err),
    .m1_addr_i(m1_addr),
    .m1_data_i(m1_wdata),
    .m1_we_i  (m1_we),
    .m1_stb_i (m1_stb),
    .m1_cyc_i (m1_cyc),
    .m1_data_o(m1_rdata),
    .m1_ack_o (m1_ack),
    .m1_err_o (m1_err),
    .s_addr_o (s_addr_o),
    .s_data_o (s_data_o),
    .s_we_o   (s_we_o),
    .s_stb_o  (s_stb_o),
    .s_cyc_o  (s_cyc_o),
    .s_data_i (s_data_i),
    .s_ack_i  (s_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    int exp_m;

    rst_n = 1'b0;
    m0_addr = '0; m0_wdata = '0; m0_we = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0;
    m1_addr = '0; m1_wdata = '0; m1_we = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
    s_data_i = '0; s_ack_i = 1'b0;

    // ---------------- reset state ----------------
    sample();
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_s_addr", s_addr_o, 0);
    chk("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    $display("txn reset released");

    // ---------------- tie after reset: m0 first ----------------
    tick();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 32'h10;
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_addr = 32'h20;
    sample();
    chk("tie_latency_cyc", s_cyc_o, 0);
    tick();
    sample();
    chk("tie_first_addr", s_addr_o, 32'h10);
    chk("tie_first_stb", s_stb_o, 1);
    tick();
    s_ack_i = 1; s_data_i = 32'hCAFE_0000;
    sample();
    chk("tie_m0_ack", {m0_ack, m1_ack}, 2'b10);
    chk("tie_m0_data", m0_rdata, 32'hCAFE_0000);
    tick();
    s_ack_i = 0; m0_cyc = 0; m0_stb = 0;
    sample();
    chk("tie_m0_drop_cyc", s_cyc_o, 0);
    tick();
    sample();
    chk("tie_idle_cyc", s_cyc_o, 0);
    chk("tie_idle_addr", s_addr_o, 0);
    tick();
    sample();
    chk("tie_second_addr", s_addr_o, 32'h20);
    chk("tie_second_cyc", s_cyc_o, 1);
    tick();
    s_ack_i = 1; s_data_i = 32'h0000_00FF;
    sample();
    chk("tie_m1_ack", {m0_ack, m1_ack}, 2'b01);
    chk("tie_m1_data", m1_rdata, 32'h0000_00FF);
    tick();
    s_ack_i = 0; m1_cyc = 0; m1_stb = 0;
    tick();
    $display("txn tie: m0 read 0xcafe0000 then m1 read 0x000000ff");

    // ---------------- fairness: 6 transactions under contention ----------------
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h100;
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h200;
    sample();
    chk("fair_setup_idle", s_cyc_o, 0);
    for (int t = 0; t < 6; t++) begin
      exp_m = t % 2;
      tick();
      sample();
      chk("fair_grant_addr", s_addr_o, (exp_m == 1) ? 32'h200 : 32'h100);
      chk("fair_grant_cyc", s_cyc_o, 1);
      tick();
      s_ack_i = 1; s_data_i = 32'h5000 + t;
      sample();
      chk("fair_ack", {m0_ack, m1_ack}, (exp_m == 1) ? 2'b01 : 2'b10);
      chk("fair_data", (exp_m == 1) ? m1_rdata : m0_rdata, 32'h5000 + t);
      tick();
      s_ack_i = 0;
      if (exp_m == 1) begin m1_cyc = 0; m1_stb = 0; end
      else begin m0_cyc = 0; m0_stb = 0; end
      if (t == 5) begin m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; end
      tick();
      if (t < 5) begin
        if (exp_m == 1) begin m1_cyc = 1; m1_stb = 1; end
        else begin m0_cyc = 1; m0_stb = 1; end
      end
      sample();
      chk("fair_idle_gap", s_cyc_o, 0);
      $display("txn fairness %0d granted m%0d", t, exp_m);
    end

    // ---------------- single write, m0 only ----------------
    tick();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'h4; m0_wdata = 32'hA5A5_0001;
    sample();
    chk("wr_latency_cyc", s_cyc_o, 0);
    tick();
    sample();
    chk("wr_s_addr", s_addr_o, 32'h4);
    chk("wr_s_data", s_data_o, 32'hA5A5_0001);
    chk("wr_s_we_stb_cyc", {s_we_o, s_stb_o, s_cyc_o}, 3'b111);
    chk("wr_no_early_ack", {m0_ack, m1_ack}, 2'b00);
    tick();
    s_ack_i = 1;
    sample();
    chk("wr_ack", {m0_ack, m1_ack, m0_err}, 3'b100);
    tick();
    s_ack_i = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
    sample();
    chk("wr_ack_single", {m0_ack, m1_ack}, 2'b00);
    tick();
    sample();
    chk("wr_release_idle", {s_cyc_o, s_we_o}, 2'b00);
    $display("txn m0 write 0xa5a50001 to 0x4");

    // ---------------- bus lock: m1 holds CYC for 3 strobes ----------------
    tick();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h300;
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h400;
    sample();
    chk("lock_latency_cyc", s_cyc_o, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      s_ack_i = 0;
      m1_addr = 32'h400 + k;
      sample();
      chk("lock_m1_addr", s_addr_o, 32'h400 + k);
      chk("lock_m0_waits", m0_ack, 0);
      tick();
      s_ack_i = 1;
      sample();
      chk("lock_ack", {m0_ack, m1_ack}, 2'b01);
      $display("txn lock strobe %0d acked to m1", k);
    end
    tick();
    s_ack_i = 0; m1_cyc = 0; m1_stb = 0;
    sample();
    chk("lock_release_m0_ack", m0_ack, 0);
    tick();
    sample();
    chk("lock_idle_gap", s_cyc_o, 0);
    tick();
    sample();
    chk("lock_m0_granted", s_addr_o, 32'h300);
    tick();
    s_ack_i = 1;
    sample();
    chk("lock_m0_ack", {m0_ack, m1_ack}, 2'b10);
    tick();
    s_ack_i = 0; m0_cyc = 0; m0_stb = 0;
    tick();
    $display("txn lock: m0 served after m1 release");

    // ---------------- watchdog timeout ----------------
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h8;
    sample();
    chk("to_idle_stb", s_stb_o, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      sample();
      chk("to_stb_high", s_stb_o, 1);
      chk("to_err", {m0_err, m1_err, m0_ack}, (i == 16) ? 3'b100 : 3'b000);
    end
    tick();
    sample();
    chk("to_stb_forced_low", s_stb_o, 0);
    chk("to_err_pulse_end", m0_err, 0);
    chk("to_cyc_held", s_cyc_o, 1);
    tick();
    m0_cyc = 0; m0_stb = 0;
    tick();
    sample();
    chk("to_back_idle", {s_cyc_o, s_stb_o}, 2'b00);
    $display("txn m0 timeout err on cycle 16");

    // ---------------- ACK on the timeout cycle wins ----------------
    tick();
    m0_cyc = 1; m0_stb = 1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      s_ack_i = (i == 16);
      sample();
      chk("ackwin_resp", {m0_ack, m0_err}, (i == 16) ? 2'b10 : 2'b00);
    end
    tick();
    s_ack_i = 0; m0_cyc = 0; m0_stb = 0;
    tick();
    $display("txn m0 ack on 16th wait cycle, no err");

    // ---------------- reset mid-operation ----------------
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h44;
    tick();
    sample();
    chk("rmid_granted_m1", {s_stb_o, s_addr_o}, {1'b1, 32'h44});
    #2;
    rst_n = 0;
    s_ack_i = 1;
    #1;
    chk("rmid_slave_zero", {s_stb_o, s_cyc_o, s_we_o}, 3'b000);
    chk("rmid_addr_zero", s_addr_o, 0);
    chk("rmid_no_resp", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
    tick();
    s_ack_i = 0; m1_cyc = 0; m1_stb = 0;
    tick();
    rst_n = 1;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h55;
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h66;
    sample();
    chk("rmid_idle_after", s_cyc_o, 0);
    tick();
    sample();
    chk("rmid_m0_first", s_addr_o, 32'h55);
    tick();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    $display("txn reset mid-transfer, m0 wins next tie");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against the run never finishing.
  initial begin
    #200000;
    $display("FAIL tb_timeout simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
